// File: rtl/hamming_secded_serial_decoder.sv
`default_nettype none
// ============================================================================
// Module  : hamming_secded_serial_decoder
// Purpose : Serial extended-Hamming decoder with a one-entry result buffer,
//           overrun pulse and saturating error statistics.
// Revision: 1.0  initial release
// ============================================================================
module hamming_secded_serial_decoder #(
    parameter int DATA_W = 4,
    parameter int PAR_W  = 3,
    parameter int SECDED = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              sync_clr,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_corrected,
    output logic              err_uncorrectable,
    output logic              overrun,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);
    localparam int N     = DATA_W + PAR_W;
    localparam int CW_W  = N + SECDED;
    localparam int OFF   = (SECDED != 0) ? 0 : 1;
    localparam int IDX_W = (CW_W > 1) ? $clog2(CW_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CW_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Codeword position carrying data bit k (non-power-of-two positions).
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == k) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CW_W-1:0]   cw_q, cw_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              corr_q, corr_d;
    logic              uncorr_q, uncorr_d;
    logic              ovr_q, ovr_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic [PAR_W-1:0]  w_syn;
    logic              w_syn_hit;
    logic              w_par;
    logic              w_is_corr;
    logic              w_is_uncorr;
    logic [DATA_W-1:0] w_data_raw;
    logic [DATA_W-1:0] w_data_fix;

    // cw_q[i] holds codeword position i+OFF.
    assign w_par = (SECDED != 0) ? (^cw_q) : 1'b0;

    always_comb begin
        w_syn = '0;
        for (int i = 1; i <= N; i++) begin
            if (cw_q[i-OFF]) w_syn = w_syn ^ i[PAR_W-1:0];
        end
        // Syndromes above N point outside the codeword.
        w_syn_hit = 1'b0;
        for (int i = 0; i <= N; i++) begin
            if (w_syn == i[PAR_W-1:0]) w_syn_hit = 1'b1;
        end
        if (SECDED != 0) begin
            w_is_corr   = w_par && w_syn_hit;
            w_is_uncorr = (w_par && !w_syn_hit) || (!w_par && (w_syn != '0));
        end else begin
            w_is_corr   = (w_syn != '0) && w_syn_hit;
            w_is_uncorr = !w_syn_hit;
        end
    end

    for (genvar k = 0; k < DATA_W; k++) begin : g_data
        localparam int DP = data_pos(k);
        assign w_data_raw[k] = cw_q[DP-OFF];
        assign w_data_fix[k] = cw_q[DP-OFF] ^ (w_is_corr && (w_syn == PAR_W'(DP)));
    end

    always_comb begin
        idx_d        = idx_q;
        cw_d         = cw_q;
        req_d        = 1'b0;
        data_d       = data_q;
        valid_d      = valid_q;
        corr_d       = corr_q;
        uncorr_d     = uncorr_q;
        ovr_d        = 1'b0;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;

        if (sync_clr) begin
            idx_d = '0;
            cw_d  = '0;
        end else if (ena && bit_valid) begin
            for (int i = 0; i < CW_W; i++) begin
                if (idx_q == i[IDX_W-1:0]) cw_d[i] = bit_in;
            end
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
                req_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        if (req_q) begin
            if (!valid_q || out_ready) begin
                data_d   = w_is_uncorr ? w_data_raw : w_data_fix;
                corr_d   = w_is_corr;
                uncorr_d = w_is_uncorr;
                valid_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
            if (w_is_corr && (corr_cnt_q != CNT_MAX))
                corr_cnt_d = corr_cnt_q + 1'b1;
            if (w_is_uncorr && (uncorr_cnt_q != CNT_MAX))
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            cw_q         <= '0;
            req_q        <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            corr_q       <= 1'b0;
            uncorr_q     <= 1'b0;
            ovr_q        <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            idx_q        <= idx_d;
            cw_q         <= cw_d;
            req_q        <= req_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
            ovr_q        <= ovr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign data_out          = data_q;
    assign out_valid         = valid_q;
    assign err_corrected     = corr_q;
    assign err_uncorrectable = uncorr_q;
    assign overrun           = ovr_q;
    assign corr_count        = corr_cnt_q;
    assign uncorr_count      = uncorr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_serial_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_hamming_secded_serial_decoder
// Purpose : Scoreboard bench for the serial SEC-DED decoder (four configs).
// Revision: 1.0  initial release
// ============================================================================
module tb_hamming_secded_serial_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ena0, ena2, ena3, sync_clr, bit_in, bit_valid, out_ready;

    logic [3:0]  d0; logic v0, c0, x0, o0; logic [7:0] cc0, uc0;
    logic [3:0]  d1; logic v1, c1, x1, o1; logic [1:0] cc1, uc1;
    logic [10:0] d2; logic v2, c2, x2, o2; logic [7:0] cc2, uc2;
    logic [3:0]  d3; logic v3, c3, x3, o3; logic [7:0] cc3, uc3;

    hamming_secded_serial_decoder #(.DATA_W(4), .PAR_W(3), .SECDED(1), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena0), .sync_clr(sync_clr), .bit_in(bit_in),
        .bit_valid(bit_valid), .data_out(d0), .out_valid(v0), .out_ready(out_ready),
        .err_corrected(c0), .err_uncorrectable(x0), .overrun(o0),
        .corr_count(cc0), .uncorr_count(uc0));

    hamming_secded_serial_decoder #(.DATA_W(4), .PAR_W(3), .SECDED(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena0), .sync_clr(sync_clr), .bit_in(bit_in),
        .bit_valid(bit_valid), .data_out(d1), .out_valid(v1), .out_ready(out_ready),
        .err_corrected(c1), .err_uncorrectable(x1), .overrun(o1),
        .corr_count(cc1), .uncorr_count(uc1));

    hamming_secded_serial_decoder #(.DATA_W(11), .PAR_W(4), .SECDED(1), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena2), .sync_clr(sync_clr), .bit_in(bit_in),
        .bit_valid(bit_valid), .data_out(d2), .out_valid(v2), .out_ready(out_ready),
        .err_corrected(c2), .err_uncorrectable(x2), .overrun(o2),
        .corr_count(cc2), .uncorr_count(uc2));

    hamming_secded_serial_decoder #(.DATA_W(4), .PAR_W(4), .SECDED(0), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena3), .sync_clr(sync_clr), .bit_in(bit_in),
        .bit_valid(bit_valid), .data_out(d3), .out_valid(v3), .out_ready(out_ready),
        .err_corrected(c3), .err_uncorrectable(x3), .overrun(o3),
        .corr_count(cc3), .uncorr_count(uc3));

    typedef struct packed {
        logic [15:0] data;
        logic        corr;
        logic        uncorr;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    exp_t q3[$];
    exp_t e0, e2, e3;
    int   checks = 0;
    int   passed = 0;

    // Reference encoder: bit p of the result is codeword position p.
    function automatic logic [31:0] encode(input logic [31:0] data, input int dw, input int pw, input bit sec);
        logic [31:0] cw;
        logic        par;
        int          k;
        cw = '0;
        k  = 0;
        for (int p = 1; p <= dw + pw; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = data[k];
                k++;
            end
        end
        for (int j = 0; j < pw; j++) begin
            par = 1'b0;
            for (int p = 1; p <= dw + pw; p++)
                if (((p >> j) & 1) == 1) par = par ^ cw[p];
            cw[1 << j] = par;
        end
        if (sec) cw[0] = ^cw;
        return cw;
    endfunction

    function automatic logic [15:0] extract(input logic [31:0] cw, input int dw, input int pw);
        logic [15:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int p = 1; p <= dw + pw; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = cw[p];
                k++;
            end
        end
        return d;
    endfunction

    always @(negedge clk) begin
        if (rst_n && v0 && out_ready) begin
            checks++;
            if (q0.size() == 0) begin
                $display("FAIL sb0_unexpected got data=%h corr=%b unc=%b, none expected", d0, c0, x0);
            end else begin
                e0 = q0.pop_front();
                if ({d0, c0, x0} !== {e0.data[3:0], e0.corr, e0.uncorr})
                    $display("FAIL sb0 got data=%h corr=%b unc=%b, want data=%h corr=%b unc=%b",
                             d0, c0, x0, e0.data[3:0], e0.corr, e0.uncorr);
                else passed++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && v2 && out_ready) begin
            checks++;
            if (q2.size() == 0) begin
                $display("FAIL sb2_unexpected got data=%h corr=%b unc=%b, none expected", d2, c2, x2);
            end else begin
                e2 = q2.pop_front();
                if ({d2, c2, x2} !== {e2.data[10:0], e2.corr, e2.uncorr})
                    $display("FAIL sb2 got data=%h corr=%b unc=%b, want data=%h corr=%b unc=%b",
                             d2, c2, x2, e2.data[10:0], e2.corr, e2.uncorr);
                else passed++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && v3 && out_ready) begin
            checks++;
            if (q3.size() == 0) begin
                $display("FAIL sb3_unexpected got data=%h corr=%b unc=%b, none expected", d3, c3, x3);
            end else begin
                e3 = q3.pop_front();
                if ({d3, c3, x3} !== {e3.data[3:0], e3.corr, e3.uncorr})
                    $display("FAIL sb3 got data=%h corr=%b unc=%b, want data=%h corr=%b unc=%b",
                             d3, c3, x3, e3.data[3:0], e3.corr, e3.uncorr);
                else passed++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_range(input logic [31:0] cw, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            bit_in    = cw[i];
            bit_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena0 = 1'b0; ena2 = 1'b0; ena3 = 1'b0;
        sync_clr = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
        idle(3);
        checks++;
        if ({d0, v0, c0, x0, o0, cc0, uc0} !== '0)
            $display("FAIL reset_dut0 got %h, want 0", {d0, v0, c0, x0, o0, cc0, uc0});
        else passed++;
        checks++;
        if ({d1, v1, c1, x1, o1, cc1, uc1} !== '0)
            $display("FAIL reset_dut1 got %h, want 0", {d1, v1, c1, x1, o1, cc1, uc1});
        else passed++;
        checks++;
        if ({d2, v2, c2, x2, o2, cc2, uc2, d3, v3, c3, x3, o3, cc3, uc3} !== '0)
            $display("FAIL reset_dut23 got %h, want 0",
                     {d2, v2, c2, x2, o2, cc2, uc2, d3, v3, c3, x3, o3, cc3, uc3});
        else passed++;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_clean();
        ena0 = 1'b1; out_ready = 1'b1;
        q0.push_back({16'h000B, 1'b0, 1'b0});
        send_range(32'h0000_00AA, 0, 7);
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0) $display("FAIL clean_latency out_valid=%b before load edge, want 0", v0);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if ({v0, d0} !== {1'b1, 4'hB}) $display("FAIL clean_load got valid=%b data=%h, want 1/b", v0, d0);
        else passed++;
        idle(2);
        checks++;
        if ({cc0, uc0} !== 16'h0000 || q0.size() != 0)
            $display("FAIL clean_counts got corr=%0d unc=%0d pending=%0d, want 0/0/0", cc0, uc0, q0.size());
        else passed++;
    endtask

    task automatic test_corrected();
        q0.push_back({16'h000B, 1'b1, 1'b0});
        send_range(32'h0000_00EA, 0, 7);
        idle(3);
        checks++;
        if (cc0 !== 8'd1 || uc0 !== 8'd0 || q0.size() != 0)
            $display("FAIL corr_counts got corr=%0d unc=%0d pending=%0d, want 1/0/0", cc0, uc0, q0.size());
        else passed++;
    endtask

    task automatic test_uncorrectable();
        q0.push_back({16'h000D, 1'b0, 1'b1});
        send_range(32'h0000_00CA, 0, 7);
        idle(3);
        checks++;
        if (cc0 !== 8'd1 || uc0 !== 8'd1 || q0.size() != 0)
            $display("FAIL uncorr_counts got corr=%0d unc=%0d pending=%0d, want 1/1/0", cc0, uc0, q0.size());
        else passed++;
    endtask

    task automatic test_overrun();
        logic [31:0] cwa, cwb, cwc;
        cwa = encode(32'h3, 4, 3, 1'b1);
        cwb = encode(32'hC, 4, 3, 1'b1);
        cwc = encode(32'h9, 4, 3, 1'b1);
        out_ready = 1'b0;
        q0.push_back({16'h0003, 1'b0, 1'b0});
        send_range(cwa, 0, 7);
        idle(1);
        send_range(cwb, 0, 7);
        @(posedge clk); #1;
        checks++;
        if ({o0, v0, d0} !== {1'b1, 1'b1, 4'h3})
            $display("FAIL ovr_pulse got ovr=%b valid=%b data=%h, want 1/1/3", o0, v0, d0);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (o0 !== 1'b0) $display("FAIL ovr_width got ovr=%b one cycle later, want 0", o0);
        else passed++;
        // Dropped frames still count toward statistics.
        send_range(cwb ^ 32'h4, 0, 7);
        idle(2);
        checks++;
        if (cc0 !== 8'd2 || d0 !== 4'h3)
            $display("FAIL ovr_dropped_count got corr=%0d data=%h, want 2/3", cc0, d0);
        else passed++;
        q0.push_back({16'h0009, 1'b0, 1'b0});
        send_range(cwc, 0, 7);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({o0, v0, d0} !== {1'b0, 1'b1, 4'h9})
            $display("FAIL ovr_accept_load got ovr=%b valid=%b data=%h, want 0/1/9", o0, v0, d0);
        else passed++;
        idle(2);
        checks++;
        if (q0.size() != 0) $display("FAIL ovr_drain pending=%0d, want 0", q0.size());
        else passed++;
    endtask

    task automatic test_ena_gap();
        logic [31:0] cw;
        cw = encode(32'h6, 4, 3, 1'b1);
        q0.push_back({16'h0006, 1'b0, 1'b0});
        send_range(cw, 0, 2);
        ena0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_in = i[0]; bit_valid = 1'b1;
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        ena0 = 1'b1;
        send_range(cw, 3, 7);
        idle(3);
        checks++;
        if (q0.size() != 0 || cc0 !== 8'd2 || uc0 !== 8'd1)
            $display("FAIL ena_gap pending=%0d corr=%0d unc=%0d, want 0/2/1", q0.size(), cc0, uc0);
        else passed++;
    endtask

    task automatic test_sync_clr();
        send_range(32'h0000_00FF, 0, 2);
        sync_clr = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(posedge clk); #1;
        sync_clr = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        q0.push_back({16'h0005, 1'b0, 1'b0});
        send_range(encode(32'h5, 4, 3, 1'b1), 0, 7);
        idle(3);
        checks++;
        if (q0.size() != 0 || cc0 !== 8'd2 || uc0 !== 8'd1)
            $display("FAIL sync_clr pending=%0d corr=%0d unc=%0d, want 0/2/1", q0.size(), cc0, uc0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        q0.push_back({16'h0007, 1'b1, 1'b0});
        q0.push_back({16'h0008, 1'b0, 1'b0});
        send_range(encode(32'h7, 4, 3, 1'b1) ^ 32'h8, 0, 7);
        send_range(encode(32'h8, 4, 3, 1'b1), 0, 7);
        idle(3);
        checks++;
        if (q0.size() != 0 || cc0 !== 8'd3)
            $display("FAIL back_to_back pending=%0d corr=%0d, want 0/3", q0.size(), cc0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_range(encode(32'h2, 4, 3, 1'b1) ^ 32'h10, 0, 7);
        idle(1);
        send_range(encode(32'hE, 4, 3, 1'b1), 0, 2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({d0, v0, c0, x0, o0, cc0, uc0} !== '0 || {cc1, uc1} !== 4'h0)
            $display("FAIL reset_mid got %h, want 0", {d0, v0, c0, x0, o0, cc0, uc0, cc1, uc1});
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        q0.push_back({16'h0001, 1'b0, 1'b0});
        send_range(encode(32'h1, 4, 3, 1'b1), 0, 7);
        idle(3);
        checks++;
        if (q0.size() != 0) $display("FAIL reset_mid_frame pending=%0d, want 0", q0.size());
        else passed++;
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 5; k++) begin
            q0.push_back({16'(k), 1'b1, 1'b0});
            send_range(encode(32'(k), 4, 3, 1'b1) ^ (32'h1 << k), 0, 7);
        end
        idle(3);
        checks++;
        if (cc0 !== 8'd5 || q0.size() != 0)
            $display("FAIL sat_wide_counter got corr=%0d pending=%0d, want 5/0", cc0, q0.size());
        else passed++;
        checks++;
        if (cc1 !== 2'd3 || uc1 !== 2'd0)
            $display("FAIL sat_counter got corr=%0d unc=%0d, want 3/0", cc1, uc1);
        else passed++;
        ena0 = 1'b0;
    endtask

    task automatic test_wide();
        logic [31:0] cw, bad;
        ena2 = 1'b1;
        cw = encode(32'h5A3, 11, 4, 1'b1);
        q2.push_back({16'h05A3, 1'b1, 1'b0});
        send_range(cw ^ (32'h1 << 13), 0, 15);
        q2.push_back({16'h02C5, 1'b0, 1'b0});
        send_range(encode(32'h2C5, 11, 4, 1'b1), 0, 15);
        bad = cw ^ (32'h1 << 3) ^ (32'h1 << 10);
        q2.push_back({extract(bad, 11, 4), 1'b0, 1'b1});
        send_range(bad, 0, 15);
        idle(3);
        checks++;
        if (cc2 !== 8'd1 || uc2 !== 8'd1 || q2.size() != 0)
            $display("FAIL wide got corr=%0d unc=%0d pending=%0d, want 1/1/0", cc2, uc2, q2.size());
        else passed++;
        ena2 = 1'b0;
    endtask

    task automatic test_sec();
        logic [31:0] cw, bad;
        ena3 = 1'b1;
        cw = encode(32'hA, 4, 4, 1'b0);
        q3.push_back({16'h000A, 1'b0, 1'b0});
        send_range(cw, 1, 8);
        q3.push_back({16'h000A, 1'b1, 1'b0});
        send_range(cw ^ (32'h1 << 8), 1, 8);
        q3.push_back({16'h000A, 1'b1, 1'b0});
        send_range(cw ^ (32'h1 << 6), 1, 8);
        bad = cw ^ (32'h1 << 7) ^ (32'h1 << 8);
        q3.push_back({extract(bad, 4, 4), 1'b0, 1'b1});
        send_range(bad, 1, 8);
        idle(3);
        checks++;
        if (cc3 !== 8'd2 || uc3 !== 8'd1 || q3.size() != 0)
            $display("FAIL sec_only got corr=%0d unc=%0d pending=%0d, want 2/1/0", cc3, uc3, q3.size());
        else passed++;
        ena3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_corrected();
        test_uncorrectable();
        test_overrun();
        test_ena_gap();
        test_sync_clr();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        test_wide();
        test_sec();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
